// File: rtl/mem_wb_stage_if.sv
// Data-memory request/acknowledge bus between the MEM stage and data memory.
// Latency: none (wires only).
// Backpressure: the master holds the request fields stable until the slave strobes dmem_ack.
//
// Signals:
//   dmem_req   - access request, held high until acknowledged
//   dmem_we    - 1 = store, 0 = load
//   dmem_addr  - byte address of the access
//   dmem_wdata - store byte
//   dmem_ack   - completion strobe from memory
//   dmem_rdata - load byte, valid in the dmem_ack cycle
interface mem_wb_stage_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [7:0]  dmem_wdata;
    logic        dmem_ack;
    logic [7:0]  dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_ack, dmem_rdata
    );
endinterface

// File: rtl/mem_wb_stage.sv
// MEM stage of the 2-issue VLIW pipeline: byte load/store over dmem and the MEM/WB register.
// Latency: 1 cycle for non-memory bundles; 1 + (cycles until ack) for memory bundles.
// Backpressure: mem_stall freezes upstream while an access is outstanding or waiting for MEM/WB.
//
// Ports:
//   clk, reset            - clock; synchronous active-low reset
//   p4_pipeline_regWrite  - MEM/WB load enable from the hazard unit
//   MEM_flush             - turns the current EX/MEM bundle into a bubble (ignored once issued)
//   p3_*                  - EX/MEM bundle: ALU-slot result and MEM-slot address/data/controls
//   dbus                  - data-memory request/ack bus (master side)
//   mem_stall             - freezes PC, p1, p2, p3
//   mem_fault             - sticky: illegal bundle or access timeout
//   p4_*                  - MEM/WB register contents
module mem_wb_stage #(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 p4_pipeline_regWrite,
    input  logic                 MEM_flush,
    input  logic                 p3_memRead,
    input  logic                 p3_memWrite,
    input  logic                 p3_alu_regWrite,
    input  logic                 p3_mem_regWrite,
    input  logic [2:0]           p3_alu_rd,
    input  logic [2:0]           p3_mem_rd,
    input  logic [7:0]           p3_mem_reg_rd,
    input  logic [31:0]          p3_alu_aluOut,
    input  logic [31:0]          p3_mem_address,
    mem_wb_stage_if.master       dbus,
    output logic                 mem_stall,
    output logic                 mem_fault,
    output logic                 p4_alu_regWrite,
    output logic                 p4_mem_regWrite,
    output logic [2:0]           p4_alu_rd,
    output logic [2:0]           p4_mem_rd,
    output logic [31:0]          p4_alu_result,
    output logic [31:0]          p4_mem_loadData
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD} state_t;

    state_t      state;
    logic [7:0]  wait_cnt;
    logic        req_q;
    logic        we_q;
    logic [31:0] addr_q;
    logic [7:0]  wdata_q;
    logic [7:0]  cap_data;
    logic        cap_mem_we;

    logic        memop;
    logic        illegal;
    logic        timeout;
    logic        done;
    logic [7:0]  fin_data;
    logic        fin_mem_we;

    assign memop   = (p3_memRead ^ p3_memWrite) & ~MEM_flush;
    assign illegal = p3_memRead & p3_memWrite & ~MEM_flush;

    // The counter reaches MAX_WAIT-1 on the MAX_WAIT-th WAIT cycle; that cycle abandons the access.
    assign timeout = (state == S_WAIT) & ~dbus.dmem_ack & (wait_cnt == 8'(MAX_WAIT - 1));
    assign done    = (state == S_WAIT) & (dbus.dmem_ack | timeout);

    // A timed-out access retires like a completed one but with no data and no writeback.
    assign fin_data   = dbus.dmem_ack ? dbus.dmem_rdata : 8'h00;
    assign fin_mem_we = dbus.dmem_ack & p3_mem_regWrite & p3_memRead;

    assign dbus.dmem_req   = req_q;
    assign dbus.dmem_we    = we_q;
    assign dbus.dmem_addr  = addr_q;
    assign dbus.dmem_wdata = wdata_q;

    // Stall drops in the cycle the bundle retires into MEM/WB so p3 advances on the same edge
    // and the held bundle is not issued a second time.
    always_comb begin
        mem_stall = 1'b0;
        unique case (state)
            S_IDLE:  mem_stall = memop;
            S_WAIT:  mem_stall = ~(done & p4_pipeline_regWrite);
            S_HOLD:  mem_stall = ~p4_pipeline_regWrite;
            default: mem_stall = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state           <= S_IDLE;
            wait_cnt        <= 8'h00;
            req_q           <= 1'b0;
            we_q            <= 1'b0;
            addr_q          <= 32'h0;
            wdata_q         <= 8'h00;
            cap_data        <= 8'h00;
            cap_mem_we      <= 1'b0;
            mem_fault       <= 1'b0;
            p4_alu_regWrite <= 1'b0;
            p4_mem_regWrite <= 1'b0;
            p4_alu_rd       <= 3'd0;
            p4_mem_rd       <= 3'd0;
            p4_alu_result   <= 32'h0;
            p4_mem_loadData <= 32'h0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (illegal) begin
                        mem_fault <= 1'b1;
                    end
                    if (memop) begin
                        addr_q   <= p3_mem_address;
                        we_q     <= p3_memWrite;
                        wdata_q  <= p3_mem_reg_rd;
                        req_q    <= 1'b1;
                        wait_cnt <= 8'h00;
                        state    <= S_WAIT;
                    end else if (p4_pipeline_regWrite) begin
                        // Stores, bubbles and illegal bundles never write the MEM-slot register.
                        p4_alu_regWrite <= p3_alu_regWrite & ~MEM_flush;
                        p4_alu_rd       <= p3_alu_rd;
                        p4_alu_result   <= p3_alu_aluOut;
                        p4_mem_regWrite <= p3_mem_regWrite & ~p3_memWrite & ~MEM_flush;
                        p4_mem_rd       <= p3_mem_rd;
                        p4_mem_loadData <= 32'h0;
                    end
                end
                S_WAIT: begin
                    if (done) begin
                        req_q <= 1'b0;
                        if (timeout) begin
                            mem_fault <= 1'b1;
                        end
                        if (p4_pipeline_regWrite) begin
                            p4_alu_regWrite <= p3_alu_regWrite;
                            p4_alu_rd       <= p3_alu_rd;
                            p4_alu_result   <= p3_alu_aluOut;
                            p4_mem_regWrite <= fin_mem_we;
                            p4_mem_rd       <= p3_mem_rd;
                            p4_mem_loadData <= {24'h0, fin_data};
                            state           <= S_IDLE;
                        end else begin
                            cap_data   <= fin_data;
                            cap_mem_we <= fin_mem_we;
                            state      <= S_HOLD;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                S_HOLD: begin
                    // p3 is frozen by mem_stall, so its fields still describe this bundle.
                    if (p4_pipeline_regWrite) begin
                        p4_alu_regWrite <= p3_alu_regWrite;
                        p4_alu_rd       <= p3_alu_rd;
                        p4_alu_result   <= p3_alu_aluOut;
                        p4_mem_regWrite <= cap_mem_we;
                        p4_mem_rd       <= p3_mem_rd;
                        p4_mem_loadData <= {24'h0, cap_data};
                        state           <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
